// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: forwarding select codes, shadow slot record and helpers
// shared by the hazard/forwarding unit and its shadow pipeline.
package hazard_forward_unit_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    localparam int SLOT_RD_W = 5;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } slot_t;
    // x0 never counts as a producer, so a live slot must write a nonzero rd
    function automatic logic slot_hit(slot_t s, logic [SLOT_RD_W-1:0] rs, logic chk);
        return chk & s.valid & s.we & (s.rd != '0) & (s.rd == rs);
    endfunction
endpackage

// File: rtl/hazard_slot_pipe.sv
// hazard_slot_pipe: three-deep EX/MEM/WB shadow of destination-register state,
// with a bubble input that inserts an empty slot into EX.
module hazard_slot_pipe
    import hazard_forward_unit_pkg::*;
(
    input  logic  clk_i,
    input  logic  reset_i,
    input  slot_t i_id,
    input  logic  i_bubble,
    output slot_t o_ex,
    output slot_t o_mem,
    output slot_t o_wb
);
    slot_t r_ex, r_mem, r_wb;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= i_bubble ? '0 : i_id;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end
    assign o_ex  = r_ex;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: ID-stage operand forwarding selects and load-use
// stall/bubble control driven from a shadow EX/MEM/WB destination pipeline.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regfile_we_i,
    input  logic                  id_detect_r1_i,
    input  logic                  id_detect_r2_i,
    input  logic                  id_is_load_i,
    input  logic                  id_is_sb_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_rs1_sel_o,
    output logic [1:0]            fwd_rs2_sel_o,
    output logic                  fwd_rs2_store_o,
    output logic                  stall_pc_o,
    output logic                  stall_ifid_o,
    output logic                  bubble_idex_o,
    output logic [CNT_W-1:0]      stall_count_o
);
    if (REG_ADDR_W != SLOT_RD_W) begin : g_width_check
        $error("REG_ADDR_W must equal SLOT_RD_W");
    end
    slot_t w_id, w_ex, w_mem, w_wb;
    logic w_h1_ex, w_h1_mem, w_h1_wb, w_h2_ex, w_h2_mem, w_h2_wb;
    logic w_load_use, w_stall, w_bubble;
    logic [1:0] w_sel1, w_sel2;
    logic [CNT_W-1:0] r_stall_count;
    assign w_id = '{valid: id_valid_i, rd: id_rd_i, we: id_regfile_we_i, is_load: id_is_load_i};
    hazard_slot_pipe u_pipe (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .i_id     (w_id),
        .i_bubble (w_bubble),
        .o_ex     (w_ex),
        .o_mem    (w_mem),
        .o_wb     (w_wb)
    );
    assign w_h1_ex  = slot_hit(w_ex,  id_rs1_i, id_detect_r1_i);
    assign w_h1_mem = slot_hit(w_mem, id_rs1_i, id_detect_r1_i);
    assign w_h1_wb  = slot_hit(w_wb,  id_rs1_i, id_detect_r1_i);
    assign w_h2_ex  = slot_hit(w_ex,  id_rs2_i, id_detect_r2_i);
    assign w_h2_mem = slot_hit(w_mem, id_rs2_i, id_detect_r2_i);
    assign w_h2_wb  = slot_hit(w_wb,  id_rs2_i, id_detect_r2_i);
    assign w_sel1 = w_h1_ex ? FWD_EX : w_h1_mem ? FWD_MEM : w_h1_wb ? FWD_WB : FWD_REG;
    assign w_sel2 = w_h2_ex ? FWD_EX : w_h2_mem ? FWD_MEM : w_h2_wb ? FWD_WB : FWD_REG;
    assign w_load_use = id_valid_i & w_ex.is_load & (w_h1_ex | w_h2_ex);
    // flush wins: the wrong-path ID instruction is squashed, never stalled
    assign w_stall  = reset_i & w_load_use & ~flush_i;
    assign w_bubble = reset_i & (w_load_use | flush_i);
    assign fwd_rs1_sel_o   = (!reset_i || (w_load_use && w_h1_ex)) ? FWD_REG : w_sel1;
    assign fwd_rs2_sel_o   = (!reset_i || (w_load_use && w_h2_ex)) ? FWD_REG : w_sel2;
    assign fwd_rs2_store_o = (fwd_rs2_sel_o != FWD_REG) & id_is_sb_i;
    assign stall_pc_o      = w_stall;
    assign stall_ifid_o    = w_stall;
    assign bubble_idex_o   = w_bubble;
    assign stall_count_o   = r_stall_count;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_stall_count <= '0;
        else if (w_stall && !(&r_stall_count))
            r_stall_count <= r_stall_count + 1'b1;
    end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Hazard and forwarding unit for the 5-stage RISC-V pipeline. It consumes the decode-stage hazard hints from the controller (`data_hazard_detect_r1/r2`, `is_load`, `is_sb`, `regfile_we`) and the decoded register fields. It keeps a shadow pipeline of destination-register state for the EX, MEM and WB slots. From these it drives the forwarding selects for the ID-stage operand muxes, and the stall and bubble controls for load-use hazards.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `CNT_W`, default 16: width of the stall event counter.

- `clk_i` in 1: clock; all state updates on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `id_valid_i` in 1: the ID stage holds a real instruction.
- `id_rs1_i` in `REG_ADDR_W`: rs1 of the ID instruction.
- `id_rs2_i` in `REG_ADDR_W`: rs2 of the ID instruction.
- `id_rd_i` in `REG_ADDR_W`: rd of the ID instruction.
- `id_regfile_we_i` in 1: the ID instruction writes rd.
- `id_detect_r1_i` in 1: rs1 is read, so check it for hazards.
- `id_detect_r2_i` in 1: rs2 is read, so check it for hazards.
- `id_is_load_i` in 1: the ID instruction is a load.
- `id_is_sb_i` in 1: the ID instruction is S- or B-type; rs2 is routed to store data or the comparator.
- `flush_i` in 1: taken branch or jump resolved in EX; the ID instruction is wrong-path.
- `fwd_rs1_sel_o` out 2: rs1 source. 00 = regfile, 01 = EX ALU result, 10 = MEM (ALU result, or read data if load), 11 = WB data.
- `fwd_rs2_sel_o` out 2: rs2 source, same encoding.
- `fwd_rs2_store_o` out 1: `fwd_rs2_sel_o` ≠ 00 and `id_is_sb_i`. Forwarded rs2 feeds the store data / comparator path, not ALU op B.
- `stall_pc_o` out 1: hold the PC.
- `stall_ifid_o` out 1: hold the IF/ID register.
- `bubble_idex_o` out 1: load a NOP into ID/EX.
- `stall_count_o` out `CNT_W`: saturating count of load-use stall cycles.

## Operation
- **Shadow state.** Three slots, EX, MEM and WB, each holding {valid, rd, we, is_load}.
- **Advance.** Every cycle the shadow shifts WB←MEM, MEM←EX, and EX←ID.
  - EX receives the ID fields with valid = `id_valid_i`.
  - EX receives valid = 0 (bubble) when `bubble_idex_o` = 1.
- **Live slot.** A slot is live when valid & we & rd ≠ 0. x0 is never a forwarding source.
- **Matching.** rs1 is matched only when `id_detect_r1_i` = 1, and rs2 only when `id_detect_r2_i` = 1. With no match, or with the detect bit low, the select is 00.
- **Priority per operand.** EX live and rd = rs gives 01. Otherwise MEM gives 10. Otherwise WB gives 11.
- **Load-use.**
  - Condition: `id_valid_i`, EX live with is_load = 1, and EX rd matches a checked rs. The condition is evaluated after the x0 and detect gating.
  - Response: `stall_pc_o` = `stall_ifid_o` = `bubble_idex_o` = 1. The fwd selects for that operand are don't-care and are driven to 00.
  - Next cycle the load sits in MEM, so the stall lasts exactly one cycle and the select becomes 10.
- **Flush.** `flush_i` = 1 forces `bubble_idex_o` = 1 and suppresses all stall outputs (flush wins over stall).
- **Counter.** `stall_count_o` increments on each stall cycle and saturates at 2^CNT_W−1.
- **Reset values.** Slots are all invalid, the counter is 0, and every output is 0.
- **Reset mid-operation.** Asynchronous assertion clears all state immediately. Outputs go to 0 in the same cycle.

## Timing
- Selects, stalls and the bubble are combinational from the ID inputs and the current shadow slots. They take effect in the same cycle.
- Shadow state and the counter update on the rising edge of `clk_i`.
- Load-use costs exactly 1 stall cycle. An ALU-to-ALU dependency costs 0 stall cycles.
- A simultaneous EX and MEM write to the same rd resolves to EX (01). The same rule applies to MEM and WB.

## Structure
- **Shared package:** the fwd select encodings (`FWD_REG`, `FWD_EX`, `FWD_MEM`, `FWD_WB`), the slot record typedef, and the controller opcode constants.
- **Sub-module:** `hazard_slot_pipe`. It is the 3-slot shadow shift register with a bubble input. The top level holds the compare, priority and stall logic.

## Test plan
- **Back-to-back ALU dependency.** `add x5` enters EX; ID holds `add x6,x5,x0` with detect_r1 = 1. Expect `fwd_rs1_sel_o` = 01 and no stall.
- **Load-use.** `lw x5` in EX; ID holds `add x7,x5,x5`. Expect one stall cycle with bubble = 1 and the counter incremented to 1. Next cycle, both selects = 10 and the stall is 0.
- **x0 destination.** An EX slot writing x0, with ID rs1 = 0. Expect select 00 and no stall.
- **Priority.** EX and MEM both write x3; ID `sw x3,0(x3)` with is_sb = 1. Expect both selects = 01 and `fwd_rs2_store_o` = 1.
- **Flush over stall.** Load-use condition with `flush_i` = 1. Expect stall = 0, bubble = 1, and the counter unchanged.
- **Reset mid-operation.** Pull `reset_i` low with live slots. Expect all outputs 0 immediately. After release, an ID instruction reading x5 gets select 00.
